dma_copy_ctrl: RTL and testbench
================================

DMA_COPY_CTRL -- requirements
Module: dma_copy_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 42, cacheline address width.
REQ-002 Parameter DATA_WIDTH, default 512, cacheline width in bits; SHALL be a multiple of 32.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 go  in  1  start-copy pulse from host control registers.
REQ-006 src_addr / dst_addr  in  ADDR_WIDTH each  source and destination cacheline addresses.
REQ-007 size  in  ADDR_WIDTH+1  number of cachelines to copy (0 legal).
REQ-008 done  out  1  copy complete; held until next accepted go.
REQ-009 dma_rd_go / dma_wr_go  out  1 each  start pulses to DMA read and write channels.
REQ-010 dma_rd_addr / dma_wr_addr  out  ADDR_WIDTH each  read and write start addresses.
REQ-011 dma_rd_size / dma_wr_size  out  ADDR_WIDTH+1 each  read and write lengths.
REQ-012 dma_rd_en  out  1  pop read-data FIFO; dma_rd_data  in  DATA_WIDTH; dma_empty  in  1.
REQ-013 dma_wr_en  out  1  write request; dma_wr_data  out  DATA_WIDTH; dma_full  in  1.
REQ-014 dma_rd_done / dma_wr_done  in  1 each  DMA channel completion flags.

Function
REQ-015 FSM states SHALL be IDLE, START, RUN, DONE.
REQ-016 IDLE or DONE with go=1 -> START; capture src_addr, dst_addr, size; clear counters; deassert done.
REQ-017 go in START or RUN SHALL be ignored; no parameter change.
REQ-018 START lasts exactly 1 cycle; dma_rd_go=dma_wr_go=1 only there; addr/size outputs show captured values; -> RUN.
REQ-019 Pop: dma_rd_en = (state==RUN) && !dma_empty && rd_count<size && (!out_valid || !dma_full).
REQ-020 Each pop loads dma_rd_data into one DATA_WIDTH output register, sets out_valid, rd_count++.
REQ-021 dma_wr_en = out_valid; dma_wr_data = output register; write accepted when dma_wr_en && !dma_full.
REQ-022 Accepted write without same-cycle pop clears out_valid; with same-cycle pop, register reloads and out_valid stays 1.
REQ-023 wr_count increments on each accepted write; read-to-write latency 1 cycle when dma_full=0.
REQ-024 Sustained throughput 1 cacheline/cycle with dma_empty=0, dma_full=0.
REQ-025 dma_full=1 with out_valid=1: register and dma_wr_data SHALL hold unchanged.
REQ-026 RUN -> DONE when wr_count==size && !out_valid && dma_rd_done && dma_wr_done.
REQ-027 size=0: no pops, no writes; RUN -> DONE once both done inputs are 1.
REQ-028 Counters ADDR_WIDTH+1 bits; no wrap; rd_count and wr_count never exceed size.
REQ-029 done=1 only in DONE.

Reset
REQ-030 rst SHALL force IDLE; done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en, out_valid = 0.
REQ-031 rst clears counters and captured size/address registers to 0; data register need not reset.
REQ-032 rst mid-RUN aborts immediately; no further pops or writes until new go after reset.

Configuration
REQ-033 Macro DMA_COPY_XFORM_EN defined: each 32-bit lane of loaded data += 1, modulo 2^32, same 1-cycle latency.
REQ-034 DMA_COPY_XFORM_EN undefined: data copied bit-exact.

Verification
REQ-035 size=4, src=0x100, dst=0x200, no stalls -> 1 START cycle with go pulses; 4 writes, data in order; done set.
REQ-036 size=0 -> zero dma_rd_en/dma_wr_en pulses; done after dma_rd_done=dma_wr_done=1.
REQ-037 size=8, dma_full high 5 cycles mid-transfer -> dma_wr_data stable while full; exactly 8 writes, no loss/dup.
REQ-038 go again during RUN with size=3 -> ignored; original size=6 completes with 6 writes.
REQ-039 rst asserted after 2 of 5 writes -> outputs 0 asynchronously; state IDLE; done=0.
REQ-040 Data word 0xFFFFFFFF in lane 0 -> 0x00000000 with DMA_COPY_XFORM_EN, 0xFFFFFFFF without.

Source files
------------

// File: rtl/dma_copy_ctrl.sv
// Cacheline copy sequencer: kicks off the DMA read/write channels and streams
// popped read data into write requests. Optional macro: DMA_COPY_XFORM_EN.
//
// state | meaning
// IDLE  | waiting for go after reset
// START | one cycle: go pulses to both DMA channels
// RUN   | streaming read FIFO to write port until size lines written
// DONE  | copy finished, done held until next go
module dma_copy_ctrl #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   size,
  output logic                  done,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [ADDR_WIDTH:0]   dma_rd_size,
  output logic [ADDR_WIDTH:0]   dma_wr_size,
  output logic                  dma_rd_en,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic                  dma_empty,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_full,
  input  logic                  dma_rd_done,
  input  logic                  dma_wr_done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int LANES = DATA_WIDTH / 32;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [CW-1:0]         size_q;
  logic [CW-1:0]         rd_count;
  logic [CW-1:0]         wr_count;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] load_data;

  logic accept_go;
  logic pop;
  logic wr_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_go = 1'b0;
    pop       = 1'b0;
    wr_accept = 1'b0;
    done      = 1'b0;
    dma_rd_go = 1'b0;
    dma_wr_go = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          accept_go = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        dma_rd_go = 1'b1;
        dma_wr_go = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // a pop is allowed only when the output register will be free next cycle
        pop       = !dma_empty && (rd_count < size_q) && (!out_valid || !dma_full);
        wr_accept = out_valid && !dma_full;
        if ((wr_count == size_q) && !out_valid && dma_rd_done && dma_wr_done)
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (go) begin
          accept_go = 1'b1;
          state_nxt = START;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      size_q    <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      out_valid <= 1'b0;
    end else if (accept_go) begin
      src_q     <= src_addr;
      dst_q     <= dst_addr;
      size_q    <= size;
      rd_count  <= '0;
      wr_count  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop)       rd_count <= rd_count + ONE;
      if (wr_accept) wr_count <= wr_count + ONE;
      if (pop)            out_valid <= 1'b1;
      else if (wr_accept) out_valid <= 1'b0;
    end
  end

`ifdef DMA_COPY_XFORM_EN
  always_comb begin
    load_data = dma_rd_data;
    for (int l = 0; l < LANES; l++)
      load_data[l*32 +: 32] = dma_rd_data[l*32 +: 32] + 32'd1;
  end
`else
  assign load_data = dma_rd_data;
`endif

  // data register carries no control meaning, so it is left unreset
  always_ff @(posedge clk) begin
    if (pop) data_q <= load_data;
  end

  assign dma_rd_en   = pop;
  assign dma_wr_en   = out_valid;
  assign dma_wr_data = data_q;
  assign dma_rd_addr = src_q;
  assign dma_wr_addr = dst_q;
  assign dma_rd_size = size_q;
  assign dma_wr_size = size_q;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Scoreboard bench for dma_copy_ctrl: expected writes queued at go, a monitor
// pops and compares on every accepted write.
module tb_dma_copy_ctrl;
  localparam int AW = 42;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   size;
  logic          done, dma_rd_go, dma_wr_go;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [AW:0]   dma_rd_size, dma_wr_size;
  logic          dma_rd_en, dma_wr_en;
  logic [DW-1:0] dma_rd_data, dma_wr_data;
  logic          dma_empty, dma_full, dma_rd_done, dma_wr_done;

  logic [DW-1:0] mem [16];
  int            rd_ptr = 0;
  int            avail;
  logic          fifo_clr;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int            total = 0;
  int            bad = 0;
  int            wr_acc = 0;
  int            rd_pulses = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;

  always #5 clk = ~clk;

  dma_copy_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .go(go), .src_addr(src_addr), .dst_addr(dst_addr),
    .size(size), .done(done), .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
    .dma_rd_en(dma_rd_en), .dma_rd_data(dma_rd_data), .dma_empty(dma_empty),
    .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_full(dma_full),
    .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
  );

  // read-data FIFO model: head word at rd_ptr, avail words in total
  always @(posedge clk) begin
    if (fifo_clr)       rd_ptr <= 0;
    else if (dma_rd_en) rd_ptr <= rd_ptr + 1;
  end
  assign dma_empty   = (rd_ptr >= avail);
  assign dma_rd_data = mem[rd_ptr[3:0]];

  function automatic logic [DW-1:0] xf(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef DMA_COPY_XFORM_EN
    for (int l = 0; l < DW/32; l++) r[l*32 +: 32] = d[l*32 +: 32] + 32'd1;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // monitor: scoreboard compare on accepted writes, stability check while full
  always @(negedge clk) begin
    if (!rst) begin
      if (held_v) begin
        chk("hold_data", dma_wr_data, held_d);
        chk("hold_wr_en", {{(DW-1){1'b0}}, dma_wr_en}, 1);
      end
      held_v <= dma_wr_en && dma_full;
      held_d <= dma_wr_data;
      if (dma_rd_en) rd_pulses <= rd_pulses + 1;
      if (dma_wr_en && !dma_full) begin
        wr_acc <= wr_acc + 1;
        got_q.push_back(dma_wr_data);
        if (exp_q.size() == 0) chk("sb_extra_write", dma_wr_data, 'x);
        else chk("sb_data", dma_wr_data, exp_q.pop_front());
      end
    end else begin
      held_v <= 1'b0;
    end
  end

  int wr_base, rd_base, got_base;

  task automatic fill(input logic [7:0] tag);
    for (int i = 0; i < 16; i++)
      mem[i] = {tag, 8'(i), 16'h0001, 32'(i) * 32'h0101_0101,
                32'hDEAD_0000 | 32'(i), 32'h7FFF_FFF0 + 32'(i)};
  endtask

  task automatic start(input int n, input logic [AW-1:0] s, input logic [AW-1:0] d);
    for (int i = 0; i < n; i++) exp_q.push_back(xf(mem[i]));
    wr_base = wr_acc;
    rd_base = rd_pulses;
    got_base = got_q.size();
    avail = n;
    fifo_clr = 1'b1;
    dma_rd_done = 1'b0;
    dma_wr_done = 1'b0;
    size = (AW+1)'(n);
    src_addr = s;
    dst_addr = d;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    fifo_clr = 1'b0;
  endtask

  task automatic wait_writes(input int n, output int cyc);
    cyc = 0;
    while ((wr_acc - wr_base) < n && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("writes_reached", DW'(wr_acc - wr_base), DW'(n));
  endtask

  task automatic finish_copy();
    int c;
    @(posedge clk); #1;
    dma_rd_done = 1'b1;
    dma_wr_done = 1'b1;
    c = 0;
    while (!done && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("done_set", {{(DW-1){1'b0}}, done}, 1);
  endtask

  initial begin
    int cyc;
    logic [31:0] lane0_exp;
    rst = 1'b1; go = 1'b0; src_addr = '0; dst_addr = '0; size = '0;
    dma_full = 1'b0; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
    fifo_clr = 1'b1; avail = 0;
    fill(8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fifo_clr = 1'b0;
    @(negedge clk);
    chk("rst_outputs", DW'({done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}), 0);
    chk("rst_size", DW'(dma_rd_size), 0);

    // basic copy of 4 lines, lane 0 of first word all ones
    fill(8'hA0);
    mem[0][31:0] = 32'hFFFF_FFFF;
    start(4, AW'('h100), AW'('h200));
    @(negedge clk);
    chk("start_go", DW'({dma_rd_go, dma_wr_go, done}), DW'(3'b110));
    chk("start_rd_addr", DW'(dma_rd_addr), DW'('h100));
    chk("start_wr_addr", DW'(dma_wr_addr), DW'('h200));
    chk("start_sizes", DW'({dma_rd_size, dma_wr_size}), DW'({43'd4, 43'd4}));
    @(negedge clk);
    chk("go_one_cycle", DW'({dma_rd_go, dma_wr_go}), 0);
    wait_writes(4, cyc);
    chk("throughput_cycles", DW'(cyc), 4);
`ifdef DMA_COPY_XFORM_EN
    lane0_exp = 32'h0000_0000;
`else
    lane0_exp = 32'hFFFF_FFFF;
`endif
    chk("lane0_word", DW'(got_q[got_base][31:0]), DW'(lane0_exp));
    finish_copy();
    repeat (3) @(negedge clk);
    chk("done_held", {{(DW-1){1'b0}}, done}, 1);
    chk("a_sb_empty", DW'(exp_q.size()), 0);

    // size 0: no traffic, done only once both channel flags are set
    start(0, AW'('h300), AW'('h400));
    @(negedge clk);
    chk("zero_done_cleared", {{(DW-1){1'b0}}, done}, 0);
    repeat (5) @(negedge clk);
    chk("zero_wait_done", {{(DW-1){1'b0}}, done}, 0);
    finish_copy();
    chk("zero_rd_pulses", DW'(rd_pulses - rd_base), 0);
    chk("zero_wr_pulses", DW'(wr_acc - wr_base), 0);

    // 8 lines with a 5-cycle write backpressure in the middle
    fill(8'hC0);
    start(8, AW'('h1000), AW'('h2000));
    wait_writes(3, cyc);
    @(posedge clk); #1 dma_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 dma_full = 1'b0;
    wait_writes(8, cyc);
    finish_copy();
    repeat (3) @(negedge clk);
    chk("full_total_writes", DW'(wr_acc - wr_base), 8);
    chk("full_total_pops", DW'(rd_pulses - rd_base), 8);
    chk("c_sb_empty", DW'(exp_q.size()), 0);

    // go during RUN is ignored
    fill(8'hD0);
    start(6, AW'('h40), AW'('h80));
    wait_writes(2, cyc);
    @(posedge clk); #1;
    go = 1'b1; size = 43'd3; src_addr = AW'('h999); dst_addr = AW'('h777);
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    chk("ignore_go_addr", DW'(dma_rd_addr), DW'('h40));
    chk("ignore_go_size", DW'(dma_wr_size), 6);
    chk("ignore_go_nostart", DW'({dma_rd_go, dma_wr_go}), 0);
    wait_writes(6, cyc);
    finish_copy();
    repeat (3) @(negedge clk);
    chk("ignore_total_writes", DW'(wr_acc - wr_base), 6);

    // reset in the middle of a 5-line copy
    fill(8'hE0);
    start(5, AW'('h500), AW'('h600));
    wait_writes(2, cyc);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("abort_outputs", DW'({done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}), 0);
    exp_q.delete();
    rd_base = rd_pulses;
    wr_base = wr_acc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_pops", DW'(rd_pulses - rd_base), 0);
    chk("abort_no_writes", DW'(wr_acc - wr_base), 0);
    chk("abort_idle", DW'({done, dma_rd_go, dma_wr_en}), 0);
    chk("abort_regs_clear", DW'({dma_rd_addr, dma_wr_size}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
